mem_responder: RTL

- Memory-side responder for the multicycle datapath's memory port: accepts one read/write request at a time over a valid/ready handshake.
- Models configurable wait states, performs the single-word access, and returns a response over a second valid/ready handshake.
- Sits between the control/datapath memory interface (the initiator) and the word-addressed storage array. Replaces the zero-latency RAM so the control FSM can be exercised against realistic latency.

---
 rtl/mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request, WAIT_CYCLES wait states,
// one-cycle word access, held response. Optional address bounds check: MEM_BOUNDS_CHECK_EN.
module mem_responder #(
   parameter int ADDRESS_SIZE = 20,
   parameter int WORD_SIZE    = 64,
   parameter int DEPTH        = 1024,
   parameter int WAIT_CYCLES  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDRESS_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0]    req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [WORD_SIZE-1:0]    resp_rdata,
   output logic                    resp_err
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

   state_e                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      write_q, write_d;
   logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
   logic [WORD_SIZE-1:0]      wdata_q, wdata_d;
   logic                      req_ready_q, req_ready_d;
   logic                      resp_valid_q, resp_valid_d;
   logic [WORD_SIZE-1:0]      resp_rdata_q, resp_rdata_d;
   logic                      resp_err_q, resp_err_d;
   logic                      mem_we;
   logic                      in_range;
   logic [IW-1:0]             idx;

   logic [WORD_SIZE-1:0] mem [DEPTH];

   assign idx = addr_q[IW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
   assign in_range = (addr_q >> IW) == '0;
`else
   assign in_range = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_we       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               state_d     = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
               cnt_d       = WAIT_LOAD;
               write_d     = req_write;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               req_ready_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_ACCESS;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_ACCESS: begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = !in_range;
            if (!in_range || write_q) resp_rdata_d = '0;
            else                      resp_rdata_d = mem[idx];
            mem_we       = write_q && in_range;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Storage is not reset; reset on the ACCESS edge still blocks the write.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[idx] <= wdata_q;
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
